// File: rtl/box_v_sum_pipelined.sv
// Vertical box-sum filter: sums a TAPS-tall single-column pixel window through a registered adder tree.
// Latency 1 + $clog2(TAPS) enabled cycles, plus 1 more when BOX_V_MEAN_EN is defined.
// Backpressure: en_i=0 freezes every stage, including valid, so the outputs hold.
//
// Optional feature macro: BOX_V_MEAN_EN (adds a rounding mean stage; data_o becomes DATA_W wide).
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   window_i            TAPS pixels, index 0 = top row
//   col_i, row_i        window-centre coordinates, carried alongside the data
//   valid_i, en_i       sample qualifier, pipeline advance
//   data_o              column sum (or mean); col_o/row_o/valid_o aligned with it
module box_v_sum_pipelined #(
  parameter  int DATA_W = 10,
  parameter  int TAPS   = 3,
  localparam int LEVELS = $clog2(TAPS),
  localparam int SUM_W  = DATA_W + $clog2(TAPS),
`ifdef BOX_V_MEAN_EN
  localparam int OUT_W  = DATA_W
`else
  localparam int OUT_W  = SUM_W
`endif
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [TAPS-1:0][DATA_W-1:0]  window_i,
  input  logic [15:0]                  col_i,
  input  logic [15:0]                  row_i,
  input  logic                         valid_i,
  input  logic                         en_i,
  output logic [OUT_W-1:0]             data_o,
  output logic [15:0]                  col_o,
  output logic [15:0]                  row_o,
  output logic                         valid_o
);

  // Number of live elements at tree level k (level 0 = registered window).
  function automatic int lvl_cnt(input int k);
    return (TAPS + (1 << k) - 1) >> k;
  endfunction

  // Every element is kept SUM_W wide; the tree bounds guarantee no overflow.
  // The array is 2*TAPS wide so the pair reads 2j/2j+1 always stay in range;
  // slots past the live count are held at zero.
  logic [SUM_W-1:0] tree_q  [LEVELS+1][2*TAPS];
  logic [15:0]      col_q   [LEVELS+1];
  logic [15:0]      row_q   [LEVELS+1];
  logic             valid_q [LEVELS+1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k <= LEVELS; k++) begin
        for (int j = 0; j < 2*TAPS; j++) tree_q[k][j] <= '0;
        col_q[k]   <= '0;
        row_q[k]   <= '0;
        valid_q[k] <= 1'b0;
      end
    end else if (en_i) begin
      // Stage 0: capture the window and its sideband.
      for (int j = 0; j < TAPS; j++)          tree_q[0][j] <= SUM_W'(window_i[j]);
      for (int j = TAPS; j < 2*TAPS; j++)     tree_q[0][j] <= '0;
      col_q[0]   <= col_i;
      row_q[0]   <= row_i;
      valid_q[0] <= valid_i;

      // Tree levels: pairwise add; an odd trailing element passes through.
      for (int k = 1; k <= LEVELS; k++) begin
        for (int j = 0; j < TAPS; j++) begin
          if (2*j + 1 < lvl_cnt(k-1))
            tree_q[k][j] <= tree_q[k-1][2*j] + tree_q[k-1][2*j+1];
          else if (2*j < lvl_cnt(k-1))
            tree_q[k][j] <= tree_q[k-1][2*j];
          else
            tree_q[k][j] <= '0;
        end
        for (int j = TAPS; j < 2*TAPS; j++) tree_q[k][j] <= '0;
        col_q[k]   <= col_q[k-1];
        row_q[k]   <= row_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

`ifdef BOX_V_MEAN_EN
  // Mean = (sum * round(2^16/TAPS) + 2^15) >> 16, clamped to the pixel range.
  localparam int          PW    = SUM_W + 18;
  localparam logic [16:0] RECIP = 17'(((1 << 17) / TAPS + 1) / 2);
  localparam logic [PW-1:0] PIX_MAX = PW'((1 << DATA_W) - 1);

  logic [PW-1:0]     prod_c;
  logic [PW-1:0]     scaled_c;
  logic [DATA_W-1:0] mean_c;

  always_comb begin
    prod_c   = PW'(tree_q[LEVELS][0]) * PW'(RECIP) + PW'(32768);
    scaled_c = prod_c >> 16;
    mean_c   = (scaled_c > PIX_MAX) ? PIX_MAX[DATA_W-1:0] : scaled_c[DATA_W-1:0];
  end

  logic [DATA_W-1:0] mean_q;
  logic [15:0]       col_m_q;
  logic [15:0]       row_m_q;
  logic              valid_m_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mean_q    <= '0;
      col_m_q   <= '0;
      row_m_q   <= '0;
      valid_m_q <= 1'b0;
    end else if (en_i) begin
      mean_q    <= mean_c;
      col_m_q   <= col_q[LEVELS];
      row_m_q   <= row_q[LEVELS];
      valid_m_q <= valid_q[LEVELS];
    end
  end

  assign data_o  = mean_q;
  assign col_o   = col_m_q;
  assign row_o   = row_m_q;
  assign valid_o = valid_m_q;
`else
  assign data_o  = tree_q[LEVELS][0];
  assign col_o   = col_q[LEVELS];
  assign row_o   = row_q[LEVELS];
  assign valid_o = valid_q[LEVELS];
`endif

endmodule

// File: tb/tb_box_v_sum_pipelined.sv
module tb_box_v_sum_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, en, valid;
  logic [2:0][9:0]  win;
  logic [15:0]      col, row;
`ifdef BOX_V_MEAN_EN
  logic [9:0]       data_o;
`else
  logic [11:0]      data_o;
`endif
  logic [15:0]      col_o, row_o;
  logic             valid_o;

  int checks = 0;
  int errors = 0;

  box_v_sum_pipelined #(.DATA_W(10), .TAPS(3)) dut (
    .clk_i(clk), .rst_i(rst), .window_i(win), .col_i(col), .row_i(row),
    .valid_i(valid), .en_i(en), .data_o(data_o), .col_o(col_o), .row_o(row_o),
    .valid_o(valid_o)
  );

`ifndef BOX_V_MEAN_EN
  // Parameter sweep instances, DATA_W=12, all inputs at full scale.
  logic              sw_valid;
  logic [16*12-1:0]  sw_win;
  logic [11:0] d1;  logic [12:0] d2;  logic [14:0] d5;  logic [15:0] d16;
  logic v1, v2, v5, v16;
  logic [15:0] c1, c2, c5, c16, r1, r2, r5, r16;

  box_v_sum_pipelined #(.DATA_W(12), .TAPS(1)) sw1 (
    .clk_i(clk), .rst_i(rst), .window_i(sw_win[1*12-1:0]), .col_i(col), .row_i(row),
    .valid_i(sw_valid), .en_i(en), .data_o(d1), .col_o(c1), .row_o(r1), .valid_o(v1));
  box_v_sum_pipelined #(.DATA_W(12), .TAPS(2)) sw2 (
    .clk_i(clk), .rst_i(rst), .window_i(sw_win[2*12-1:0]), .col_i(col), .row_i(row),
    .valid_i(sw_valid), .en_i(en), .data_o(d2), .col_o(c2), .row_o(r2), .valid_o(v2));
  box_v_sum_pipelined #(.DATA_W(12), .TAPS(5)) sw5 (
    .clk_i(clk), .rst_i(rst), .window_i(sw_win[5*12-1:0]), .col_i(col), .row_i(row),
    .valid_i(sw_valid), .en_i(en), .data_o(d5), .col_o(c5), .row_o(r5), .valid_o(v5));
  box_v_sum_pipelined #(.DATA_W(12), .TAPS(16)) sw16 (
    .clk_i(clk), .rst_i(rst), .window_i(sw_win), .col_i(col), .row_i(row),
    .valid_i(sw_valid), .en_i(en), .data_o(d16), .col_o(c16), .row_o(r16), .valid_o(v16));
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int a, input int b, input int c);
    win[0] = 10'(a);
    win[1] = 10'(b);
    win[2] = 10'(c);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; valid = 1'b0; col = '0; row = '0;
    set_win(0, 0, 0);
`ifndef BOX_V_MEAN_EN
    sw_valid = 1'b0;
    sw_win   = '1;
`endif
    step();
    step();
    rst = 1'b0;
    check_val("rst_data",  32'(data_o),  0);
    check_val("rst_col",   32'(col_o),   0);
    check_val("rst_row",   32'(row_o),   0);
    check_val("rst_valid", 32'(valid_o), 0);

`ifdef BOX_V_MEAN_EN
    begin
      int ws [3][3] = '{'{1023, 1023, 1023}, '{0, 0, 1}, '{1, 1, 0}};
      int exp_mean [3] = '{1023, 0, 1};
      for (int i = 0; i < 6; i++) begin
        if (i < 3) begin
          set_win(ws[i][0], ws[i][1], ws[i][2]);
          valid = 1'b1; col = 16'(i + 40);
        end else begin
          valid = 1'b0;
        end
        step();
        if (i < 3) check_val("mean_lat_valid", 32'(valid_o), 0);
        if (i >= 3) begin
          check_val("mean_data",  32'(data_o),  32'(exp_mean[i-3]));
          check_val("mean_col",   32'(col_o),   32'(i - 3 + 40));
          check_val("mean_valid", 32'(valid_o), 1);
        end
      end
    end
`else
    // Full-scale window, exact latency 3.
    set_win(1023, 1023, 1023); col = 16'd5; row = 16'd7; valid = 1'b1;
    step();
    valid = 1'b0; set_win(0, 0, 0); col = '0; row = '0;
    step();
    check_val("t1_early_valid", 32'(valid_o), 0);
    step();
    check_val("t1_data",  32'(data_o),  3069);
    check_val("t1_col",   32'(col_o),   5);
    check_val("t1_row",   32'(row_o),   7);
    check_val("t1_valid", 32'(valid_o), 1);
    step();
    check_val("t1_bubble", 32'(valid_o), 0);

    // Streaming, one result per cycle.
    for (int n = 0; n < 102; n++) begin
      if (n < 100) begin
        set_win(n, 2*n, 3*n); col = 16'(n); row = 16'(200 - n); valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      step();
      if (n >= 2) begin
        check_val("t2_data",  32'(data_o),  32'(6*(n-2)));
        check_val("t2_col",   32'(col_o),   32'(n-2));
        check_val("t2_valid", 32'(valid_o), 1);
      end
    end
    set_win(0, 0, 0); valid = 1'b0;
    step(); step(); step();

    // Stall with changing inputs; only the accepted sample may emerge.
    set_win(10, 20, 30); col = 16'd9; row = 16'd11; valid = 1'b1;
    step();
    en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      set_win(500 + s, 500, 500); col = 16'(99 + s); valid = 1'b1;
      step();
      check_val("t3_frozen_valid", 32'(valid_o), 0);
      check_val("t3_frozen_data",  32'(data_o),  0);
    end
    en = 1'b1; valid = 1'b0; set_win(7, 7, 7); col = '0;
    step();
    check_val("t3_resume_early", 32'(valid_o), 0);
    step();
    check_val("t3_data",  32'(data_o),  60);
    check_val("t3_col",   32'(col_o),   9);
    check_val("t3_valid", 32'(valid_o), 1);
    step();
    check_val("t3_no_stall_sample", 32'(valid_o), 0);

    // Reset mid-flight while stalled: reset wins.
    set_win(1, 1, 1); valid = 1'b1; col = 16'd1; step();
    set_win(2, 2, 2); col = 16'd2; step();
    rst = 1'b1; en = 1'b0; step();
    rst = 1'b0;
    check_val("t4_data",  32'(data_o),  0);
    check_val("t4_col",   32'(col_o),   0);
    check_val("t4_valid", 32'(valid_o), 0);
    en = 1'b1; valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      check_val("t4_flushed_valid", 32'(valid_o), 0);
    end
    set_win(4, 5, 6); col = 16'd3; valid = 1'b1; step();
    valid = 1'b0; step();
    check_val("t4_new_early", 32'(valid_o), 0);
    step();
    check_val("t4_new_data",  32'(data_o),  15);
    check_val("t4_new_valid", 32'(valid_o), 1);

    // Parameter sweep: TAPS 1,2,5,16 at latency 1,2,4,5.
    step();
    sw_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      sw_valid = 1'b0;
      check_val("t5_v1",  32'(v1),  32'(c == 1));
      check_val("t5_v2",  32'(v2),  32'(c == 2));
      check_val("t5_v5",  32'(v5),  32'(c == 4));
      check_val("t5_v16", 32'(v16), 32'(c == 5));
      if (c == 1) check_val("t5_d1",  32'(d1),  4095);
      if (c == 2) check_val("t5_d2",  32'(d2),  8190);
      if (c == 4) check_val("t5_d5",  32'(d5),  20475);
      if (c == 5) check_val("t5_d16", 32'(d16), 65520);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/box_v_sum_pipelined.md
Name: box_v_sum_pipelined

Overview:
- Parametrised vertical box-sum filter for the dfdd pixel pipeline.
- Takes a TAPS-tall, one-column window of unsigned pixels and produces the exact column sum (optionally the column mean).
- Uses a registered binary adder tree: one register stage per tree level.
- Pipeline-wide enable lets it hold under downstream stall.
- col/row/valid travel in lockstep with the data.

Parameters:
- DATA_W, 10, width of each unsigned input pixel (1..16).
- TAPS, 3, window height / number of summed pixels (1..16).
- LEVELS, $clog2(TAPS), number of adder-tree levels (derived, not overridden).
- SUM_W, DATA_W + $clog2(TAPS), exact sum width (derived).
- OUT_W, SUM_W (or DATA_W when BOX_V_MEAN_EN is defined), data_o width (derived).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- window_i  in  DATA_W x [TAPS][1]  vertical window; index 0 = top row.
- col_i  in  16  column coordinate of the window centre.
- row_i  in  16  row coordinate of the window centre.
- valid_i  in  1  window/col/row qualifier.
- en_i  in  1  pipeline advance; 0 = every pipeline register holds.
- data_o  out  OUT_W  box sum (or mean).
- col_o  out  16  col_i delayed to match data_o.
- row_o  out  16  row_i delayed to match data_o.
- valid_o  out  1  data_o qualifier.

Behaviour:
- Reset: rst_i=1 at a rising edge clears every pipeline register (data, col, row, valid) to 0, regardless of en_i. Next cycle data_o=0, col_o=0, row_o=0, valid_o=0. In-flight samples are discarded; there is no partial flush.
- Stage 0: registers window_i, col_i, row_i and valid_i when en_i=1.
- Tree level k (1..LEVELS): element j = element 2j + element 2j+1 of level k-1, widened by 1 bit and registered.
  - An odd trailing element passes through zero-extended and registered, so it stays aligned.
  - col/row/valid shift with the data at every level.
- Latency: L = 1 + LEVELS cycles from input sample to data_o, counted in enabled cycles.
  - TAPS=1 -> L=1; TAPS=3 -> L=3; TAPS=16 -> L=5.
- Arithmetic: unsigned and exact, no wrap. Maximum result = TAPS*(2^DATA_W-1), which fits SUM_W.
- Enable:
  - en_i=0 freezes all stages, including valid, and outputs stay constant.
  - Inputs presented while en_i=0 are ignored (not captured).
  - en_i=1 with valid_i=0 inserts a bubble: valid_o=0 L cycles later, while data/col/row still shift.
- Simultaneous rst_i=1 and en_i=0: reset wins.
- Back-to-back valid inputs sustain one result per enabled cycle. No internal throttling; throughput is 1.
- Output timing: outputs are driven directly from the last register stage. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro: BOX_V_MEAN_EN.
- Defined:
  - One extra register stage is added after the tree, so latency = L+1.
  - Computes mean = (sum * RECIP + 2^15) >> 16, with RECIP = round(2^16 / TAPS) as a localparam.
  - Result is clamped to 2^DATA_W-1; data_o is DATA_W wide.
  - The extra stage obeys rst_i/en_i exactly like the others.
  - col/row/valid get one extra delay stage.
- Undefined: no mean stage; data_o = exact SUM_W-bit sum, latency L.

Test Plan:
1. DATA_W=10, TAPS=3 sum build. Window {1023,1023,1023}, col=5, row=7, valid=1, en=1 -> after exactly 3 cycles: data_o=3069, col_o=5, row_o=7, valid_o=1.
2. Streaming: valid every cycle with window {n, 2n, 3n} for n=0..99 -> data_o = 6n in order, one per cycle, valid_o continuous.
3. Stall: sample {10,20,30} accepted, then en_i=0 for 4 cycles with changing inputs -> outputs frozen. Resuming en_i=1 -> data_o=60 after the remaining enabled cycles; no stall-period input appears.
4. Reset mid-flight: 2 valid samples in pipeline, rst_i=1 for 1 cycle with en_i=0 -> next cycle all outputs 0, valid_o stays 0 until new input + 3 cycles.
5. Parameter sweep TAPS=1,2,5,16 with DATA_W=12, all-max inputs -> data_o = TAPS*4095 at latency 1,2,4,5 respectively.
6. BOX_V_MEAN_EN, TAPS=3, DATA_W=10:
   - {1023,1023,1023} -> 1023.
   - {0,0,1} -> 0.
   - {1,1,0} -> 1.
   - All at latency 4.
